// File: rtl/video_stream_switch.sv
`default_nettype none
// ============================================================================
// Module   : video_stream_switch
// Purpose  : Frame-aligned N:1 video stream switch with a registered output
//            stage. Optional macro VIDEO_SWITCH_BLANK_EN emits black beats
//            while re-aligning to a new source.
// Revision : 1.0 - initial release
// ============================================================================

package video_stream_switch_pkg;
   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } vga_fc_t;
endpackage

module video_stream_switch
   import video_stream_switch_pkg::*;
#(
   parameter int RGB_SIZE    = 12,
   parameter int NUM_SRC     = 4,
   parameter int DEFAULT_SEL = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_SRC-1:0]                 src_vld,
   output logic [NUM_SRC-1:0]                 src_rdy,
   input  vga_fc_t [NUM_SRC-1:0]              src_fc,
   input  logic [NUM_SRC-1:0][RGB_SIZE-1:0]   src_rgb,
   input  logic                               snk_rdy,
   output logic                               snk_vld,
   output vga_fc_t                            snk_fc,
   output logic [RGB_SIZE-1:0]                snk_rgb,
   input  logic                               sel_req_vld,
   input  logic [$clog2(NUM_SRC)-1:0]         sel_req,
   output logic [$clog2(NUM_SRC)-1:0]         cur_sel,
   output logic                               switch_busy
);

   localparam int                 c_sel_w       = $clog2(NUM_SRC);
   localparam logic [c_sel_w:0]   c_num_src     = (c_sel_w+1)'(NUM_SRC);
   localparam logic [c_sel_w-1:0] c_default_sel = c_sel_w'(DEFAULT_SEL);

   typedef enum logic [0:0] {
      ST_ALIGN = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_sel_w-1:0]   r_cur_sel;
   logic [c_sel_w-1:0]   w_cur_sel_nxt;
   logic                 r_pending;
   logic                 w_pending_nxt;
   logic [c_sel_w-1:0]   r_pending_sel;
   logic [c_sel_w-1:0]   w_pending_sel_nxt;

   logic                 r_snk_vld;
   vga_fc_t              r_snk_fc;
   logic [RGB_SIZE-1:0]  r_snk_rgb;

   logic                 w_out_ready;
   logic                 w_cur_vld;
   logic                 w_cur_sof;
   vga_fc_t              w_cur_fc;
   logic [RGB_SIZE-1:0]  w_cur_rgb;
   logic                 w_cur_rdy;
   logic                 w_fwd;
   vga_fc_t              w_fwd_fc;
   logic [RGB_SIZE-1:0]  w_fwd_rgb;
   logic                 w_req_ok;

   assign w_out_ready = ~r_snk_vld | snk_rdy;
   assign w_cur_vld   = src_vld[r_cur_sel];
   assign w_cur_fc    = src_fc[r_cur_sel];
   assign w_cur_rgb   = src_rgb[r_cur_sel];
   assign w_cur_sof   = w_cur_fc.sof;

   // Re-requesting the live source while nothing is queued would force a needless realign.
   assign w_req_ok = sel_req_vld
                   & ({1'b0, sel_req} < c_num_src)
                   & ~((r_state == ST_RUN) & ~r_pending & (sel_req == r_cur_sel));

   always_comb begin
      w_state_nxt       = r_state;
      w_cur_sel_nxt     = r_cur_sel;
      w_pending_nxt     = r_pending;
      w_pending_sel_nxt = r_pending_sel;
      w_cur_rdy         = 1'b1;
      w_fwd             = 1'b0;
      w_fwd_fc          = w_cur_fc;
      w_fwd_rgb         = w_cur_rgb;

      case (r_state)
         ST_RUN: begin
            if (r_pending & w_cur_vld & w_cur_sof) begin
               // Hold back the old source's next sof; it is drained once deselected.
               w_cur_rdy     = 1'b0;
               w_cur_sel_nxt = r_pending_sel;
               w_pending_nxt = 1'b0;
               w_state_nxt   = ST_ALIGN;
            end else begin
               w_cur_rdy = w_out_ready;
               w_fwd     = w_cur_vld & w_out_ready;
            end
         end
         default: begin
            if (r_pending) begin
               w_cur_sel_nxt = r_pending_sel;
               w_pending_nxt = 1'b0;
            end else begin
`ifdef VIDEO_SWITCH_BLANK_EN
               w_cur_rdy = w_out_ready;
               w_fwd     = w_cur_vld & w_out_ready;
               if (!w_cur_sof) begin
                  w_fwd_rgb = '0;
               end
`else
               w_cur_rdy = w_cur_sof ? w_out_ready : 1'b1;
               w_fwd     = w_cur_vld & w_cur_sof & w_out_ready;
`endif
               if (w_cur_vld & w_cur_sof & w_out_ready) begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
      endcase

      // A fresh strobe always survives a switch that consumes the older request.
      if (w_req_ok) begin
         w_pending_nxt     = 1'b1;
         w_pending_sel_nxt = sel_req;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_ALIGN;
         r_cur_sel     <= c_default_sel;
         r_pending     <= 1'b0;
         r_pending_sel <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_cur_sel     <= w_cur_sel_nxt;
         r_pending     <= w_pending_nxt;
         r_pending_sel <= w_pending_sel_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_snk_vld <= 1'b0;
         r_snk_fc  <= '0;
         r_snk_rgb <= '0;
      end else if (w_fwd) begin
         r_snk_vld <= 1'b1;
         r_snk_fc  <= w_fwd_fc;
         r_snk_rgb <= w_fwd_rgb;
      end else if (snk_rdy) begin
         r_snk_vld <= 1'b0;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src_rdy
         assign src_rdy[gi] = (r_cur_sel == c_sel_w'(gi)) ? w_cur_rdy : 1'b1;
      end
   endgenerate

   assign snk_vld     = r_snk_vld;
   assign snk_fc      = r_snk_fc;
   assign snk_rgb     = r_snk_rgb;
   assign cur_sel     = r_cur_sel;
   assign switch_busy = r_pending | (r_state == ST_ALIGN);

endmodule
`default_nettype wire

// File: tb/tb_video_stream_switch.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_stream_switch
// Purpose  : Randomised self-checking bench for video_stream_switch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_stream_switch;
   import video_stream_switch_pkg::*;

   localparam int NSRC = 4;
   localparam int RGB  = 12;
   localparam int SW   = 2;
   localparam int FL   = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NSRC-1:0]           src_vld, src_rdy;
   vga_fc_t [NSRC-1:0]        src_fc;
   logic [NSRC-1:0][RGB-1:0]  src_rgb;
   logic                      snk_rdy, snk_vld;
   vga_fc_t                   snk_fc;
   logic [RGB-1:0]            snk_rgb;
   logic                      sel_req_vld;
   logic [SW-1:0]             sel_req, cur_sel;
   logic                      switch_busy;

   logic [2:0]                b_src_vld, b_src_rdy;
   vga_fc_t [2:0]             b_src_fc;
   logic [2:0][RGB-1:0]       b_src_rgb;
   logic                      b_snk_rdy, b_snk_vld;
   vga_fc_t                   b_snk_fc;
   logic [RGB-1:0]            b_snk_rgb;
   logic                      b_sel_req_vld;
   logic [1:0]                b_sel_req, b_cur_sel;
   logic                      b_switch_busy;

   video_stream_switch #(.RGB_SIZE(RGB), .NUM_SRC(NSRC), .DEFAULT_SEL(0)) dut (
      .clk(clk), .rst(rst),
      .src_vld(src_vld), .src_rdy(src_rdy), .src_fc(src_fc), .src_rgb(src_rgb),
      .snk_rdy(snk_rdy), .snk_vld(snk_vld), .snk_fc(snk_fc), .snk_rgb(snk_rgb),
      .sel_req_vld(sel_req_vld), .sel_req(sel_req), .cur_sel(cur_sel),
      .switch_busy(switch_busy)
   );

   video_stream_switch #(.RGB_SIZE(RGB), .NUM_SRC(3), .DEFAULT_SEL(0)) dut3 (
      .clk(clk), .rst(rst),
      .src_vld(b_src_vld), .src_rdy(b_src_rdy), .src_fc(b_src_fc), .src_rgb(b_src_rgb),
      .snk_rdy(b_snk_rdy), .snk_vld(b_snk_vld), .snk_fc(b_snk_fc), .snk_rgb(b_snk_rgb),
      .sel_req_vld(b_sel_req_vld), .sel_req(b_sel_req), .cur_sel(b_cur_sel),
      .switch_busy(b_switch_busy)
   );

   typedef struct packed {
      vga_fc_t        fc;
      logic [RGB-1:0] rgb;
   } beat_t;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference: aligned flag, routed source, queued request, and the output register as a queue.
   bit    m_run;
   int    m_sel;
   bit    m_pend;
   int    m_pend_sel;
   beat_t m_out[$];
   int    n_pop  = 0;
   int    n_sink = 0;

   int s_pos[NSRC];
   int s_frm[NSRC];
   bit s_vld[NSRC];

   function automatic vga_fc_t mk_fc(int pos);
      vga_fc_t f;
      f.sof = (pos == 0);
      f.eol = (pos % 3 == 2);
      f.eof = (pos == FL - 1);
      return f;
   endfunction

   function automatic logic [RGB-1:0] mk_rgb(int s, int frm, int pos);
      return RGB'((s << 9) | ((frm % 32) << 4) | pos);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_sources();
      for (int i = 0; i < NSRC; i++) begin
         src_vld[i] = s_vld[i];
         src_fc[i]  = mk_fc(s_pos[i]);
         src_rgb[i] = mk_rgb(i, s_frm[i], s_pos[i]);
      end
   endtask

   task automatic cycle(input bit rdy, input bit req_v, input int req);
      logic [NSRC-1:0] e_rdy;
      bit    out_ready, fwd, cv, cs, nrun, npend;
      int    nsel;
      beat_t b;
      snk_rdy     = rdy;
      sel_req_vld = req_v;
      sel_req     = SW'(req);
      drive_sources();
      #1;
      out_ready = (m_out.size() == 0) || rdy;
      e_rdy = '1;
      fwd   = 1'b0;
      cv    = s_vld[m_sel];
      cs    = (s_pos[m_sel] == 0);
      nsel  = m_sel;
      nrun  = m_run;
      npend = m_pend;
      b.fc  = mk_fc(s_pos[m_sel]);
      b.rgb = mk_rgb(m_sel, s_frm[m_sel], s_pos[m_sel]);
      if (m_run) begin
         if (m_pend && cv && cs) begin
            e_rdy[m_sel] = 1'b0;
            nsel  = m_pend_sel;
            npend = 1'b0;
            nrun  = 1'b0;
         end else begin
            e_rdy[m_sel] = out_ready;
            fwd = cv && out_ready;
         end
      end else if (m_pend) begin
         nsel  = m_pend_sel;
         npend = 1'b0;
      end else begin
`ifdef VIDEO_SWITCH_BLANK_EN
         e_rdy[m_sel] = out_ready;
         fwd = cv && out_ready;
         if (!cs) b.rgb = '0;
`else
         e_rdy[m_sel] = cs ? out_ready : 1'b1;
         fwd = cv && cs && out_ready;
`endif
         if (cv && cs && out_ready) nrun = 1'b1;
      end
      if (req_v && req < NSRC && !(m_run && !m_pend && req == m_sel)) begin
         npend      = 1'b1;
         m_pend_sel = req;
      end

      chk("src_rdy", 32'(src_rdy), 32'(e_rdy));
      chk("cur_sel", 32'(cur_sel), 32'(m_sel));
      chk("switch_busy", 32'(switch_busy), 32'(m_pend || !m_run));
      chk("snk_vld", 32'(snk_vld), 32'(m_out.size() != 0));
      if (m_out.size() != 0) begin
         chk("snk_fc", 32'(snk_fc), 32'(m_out[0].fc));
         chk("snk_rgb", 32'(snk_rgb), 32'(m_out[0].rgb));
      end

      if (snk_vld && rdy) n_sink++;
      if (m_out.size() != 0 && rdy) begin
         void'(m_out.pop_front());
         n_pop++;
      end
      if (fwd) m_out.push_back(b);
      for (int i = 0; i < NSRC; i++) begin
         if (s_vld[i] && e_rdy[i]) begin
            if (s_pos[i] == FL - 1) begin
               s_pos[i] = 0;
               s_frm[i]++;
            end else begin
               s_pos[i]++;
            end
            s_vld[i] = ($urandom_range(0, 3) != 0);
         end else if (!s_vld[i]) begin
            s_vld[i] = ($urandom_range(0, 3) != 0);
         end
      end
      m_sel  = nsel;
      m_run  = nrun;
      m_pend = npend;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk("rst_snk_vld", 32'(snk_vld), 32'd0);
      chk("rst_snk_rgb", 32'(snk_rgb), 32'd0);
      chk("rst_cur_sel", 32'(cur_sel), 32'd0);
      chk("rst_busy", 32'(switch_busy), 32'd1);
      m_out.delete();
      m_run      = 1'b0;
      m_sel      = 0;
      m_pend     = 1'b0;
      m_pend_sel = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_run(input int sel, input string tag);
      for (int k = 0; k < 300 && !(m_run && m_sel == sel && !m_pend); k++)
         cycle($urandom_range(0, 3) != 0, 1'b0, 0);
      chk({tag, "_sel"}, 32'(cur_sel), 32'(sel));
      chk({tag, "_busy"}, 32'(switch_busy), 32'd0);
   endtask

   task automatic wait_pos(input int pos);
      for (int k = 0; k < 300 && s_pos[m_sel] != pos; k++)
         cycle(1'b1, 1'b0, 0);
   endtask

   initial begin
      rst = 1'b0; snk_rdy = 1'b0; sel_req_vld = 1'b0; sel_req = '0;
      b_src_vld = '0; b_src_fc = '0; b_src_rgb = '0; b_snk_rdy = 1'b1;
      b_sel_req_vld = 1'b0; b_sel_req = '0;
      for (int i = 0; i < NSRC; i++) begin
         s_pos[i] = $urandom_range(1, FL - 1);
         s_frm[i] = 0;
         s_vld[i] = 1'b1;
      end
      drive_sources();
      do_reset();

      // Lock onto the default source, then stream with random back-pressure.
      wait_run(0, "align0");
      repeat (30) cycle($urandom_range(0, 3) != 0, 1'b0, 0);

      // Mid-frame switch to source 2.
      wait_pos(2);
      cycle(1'b1, 1'b1, 2);
      wait_run(2, "sw2");

      // Sink stalls across the switch point to source 1.
      wait_pos(2);
      cycle(1'b1, 1'b1, 1);
      for (int k = 0; k < 300 && !(s_vld[m_sel] && s_pos[m_sel] == 0); k++)
         cycle(1'b1, 1'b0, 0);
      repeat (5) cycle(1'b0, 1'b0, 0);
      wait_run(1, "sw1");

      // Two strobes in one frame: the later one wins.
      wait_pos(1);
      cycle(1'b1, 1'b1, 0);
      cycle(1'b1, 1'b0, 0);
      cycle(1'b1, 1'b1, 3);
      wait_run(3, "dbl");

      // Request for the live source in RUN is a no-op.
      cycle(1'b1, 1'b1, 3);
      chk("same_sel_busy", 32'(switch_busy), 32'd0);
      chk("same_sel_cur", 32'(cur_sel), 32'd3);

      // Out-of-range request on the 3-source instance.
      b_src_vld = 3'b001;
      b_src_fc[0] = mk_fc(0);
      cycle(1'b1, 1'b0, 0);
      b_src_vld = 3'b000;
      chk("b_run_busy", 32'(b_switch_busy), 32'd0);
      b_sel_req_vld = 1'b1; b_sel_req = 2'd3;
      cycle(1'b1, 1'b0, 0);
      b_sel_req_vld = 1'b0;
      chk("b_oor_busy", 32'(b_switch_busy), 32'd0);
      chk("b_oor_sel", 32'(b_cur_sel), 32'd0);
      b_sel_req_vld = 1'b1; b_sel_req = 2'd2;
      cycle(1'b1, 1'b0, 0);
      b_sel_req_vld = 1'b0;
      chk("b_req_busy", 32'(b_switch_busy), 32'd1);

      // Random requests and back-pressure.
      for (int k = 0; k < 400; k++)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, NSRC - 1));

      // Reset mid-frame with a beat parked in the output register.
      wait_run(m_sel, "pre_rst");
      repeat (3) cycle(1'b0, 1'b0, 0);
      do_reset();
      wait_run(0, "post_rst");
      repeat (20) cycle($urandom_range(0, 3) != 0, 1'b0, 0);

      chk("beat_count", 32'(n_sink), 32'(n_pop));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
